// File: rtl/sync_debounce.sv
// sync_debounce
//   Conditions an asynchronous, possibly bouncing input into a clean level in
//   the clk_i domain. raw_i passes through a SYNC_STAGES-deep synchroniser.
//   A counter-based debouncer then moves sign_o to the new level. The new
//   level must persist for DEBOUNCE_CYCLES enabled ticks (en_i) after the
//   mismatch is first seen.
//
// Ports
//   clk_i   in   system clock, rising edge
//   rstn_i  in   asynchronous active-low reset
//   raw_i   in   asynchronous raw input
//   en_i    in   debounce tick enable (tie high for per-clock counting)
//   sign_o  out  debounced level, registered
//   chg_o   out  one-cycle pulse coincident with a sign_o change, registered
//   busy_o  out  high while a candidate level change is being qualified
module sync_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic raw_i,
  input  logic en_i,
  output logic sign_o,
  output logic chg_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   sign_r;
  logic                   chg_r;
  logic                   busy_r;

  // Synchroniser chain: raw_i enters at bit 0; only the last stage is used.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Debounce FSM with registered sign/chg/busy outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= ST_STABLE;
      cnt_r   <= '0;
      sign_r  <= RESET_VAL;
      chg_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      chg_r <= 1'b0;
      case (state_r)
        ST_STABLE: begin
          cnt_r <= '0;
          if (sync_s != sign_r) begin
            // The entry edge itself is not a debounce tick.
            state_r <= ST_CHECK;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_STABLE;
            busy_r  <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (sync_s == sign_r) begin
            // Input fell back before qualifying; this wins even on the
            // edge that would otherwise complete the count.
            state_r <= ST_STABLE;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
          end else if (en_i && (cnt_r == CNT_LAST)) begin
            sign_r  <= sync_s;
            chg_r   <= 1'b1;
            state_r <= ST_STABLE;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
          end else if (en_i) begin
            cnt_r   <= cnt_r + CNT_ONE;
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        default: begin
          state_r <= ST_STABLE;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign sign_o = sign_r;
  assign chg_o  = chg_r;
  assign busy_o = busy_r;

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce
//   Directed bench for sync_debounce. The main instance uses the default
//   parameters (2 sync stages, 16 debounce cycles). A second instance uses
//   DEBOUNCE_CYCLES = 1. Edge numbering: an input driven just after a
//   rising edge is first sampled at "edge 0"; outputs are sampled 1 time
//   unit after each rising edge.
module tb_sync_debounce;

  logic clk;
  logic rstn;
  logic raw;
  logic en;
  logic sign;
  logic chg;
  logic busy;
  logic raw1;
  logic sign1;
  logic chg1;
  logic busy1;

  int vectors;
  int miscompares;

  sync_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16),
    .RESET_VAL      (1'b0)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .raw_i (raw),
    .en_i  (en),
    .sign_o(sign),
    .chg_o (chg),
    .busy_o(busy)
  );

  sync_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(1),
    .RESET_VAL      (1'b0)
  ) dut1 (
    .clk_i (clk),
    .rstn_i(rstn),
    .raw_i (raw1),
    .en_i  (1'b1),
    .sign_o(sign1),
    .chg_o (chg1),
    .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset held with raw toggling, then released with raw low.
  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      raw = ~raw;
      step();
      vectors++;
      if ({sign, chg, busy, sign1, chg1, busy1} !== 6'b000000) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: got %b expected 000000", i,
                 {sign, chg, busy, sign1, chg1, busy1});
      end
    end
    raw  = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if ({sign, chg, busy, sign1, chg1, busy1} !== 6'b000000) begin
        miscompares++;
        $display("FAIL reset_release cycle %0d: got %b expected 000000", i,
                 {sign, chg, busy, sign1, chg1, busy1});
      end
    end
  endtask

  // Clean step to new_lvl: busy from edge 2, sign/chg at edge 18.
  task automatic test_step(input logic new_lvl);
    logic old_lvl;
    logic exp_sign;
    logic exp_chg;
    logic exp_busy;
    old_lvl = ~new_lvl;
    raw = new_lvl;
    for (int e = 0; e <= 20; e++) begin
      step();
      exp_sign = (e >= 18) ? new_lvl : old_lvl;
      exp_chg  = (e == 18);
      exp_busy = (e >= 2) && (e < 18);
      vectors++;
      if ({sign, chg, busy} !== {exp_sign, exp_chg, exp_busy}) begin
        miscompares++;
        $display("FAIL step_to_%b edge %0d: sign/chg/busy got %b expected %b",
                 new_lvl, e, {sign, chg, busy}, {exp_sign, exp_chg, exp_busy});
      end
    end
  endtask

  // Pulse of len clocks from sign=0. 16 is rejected; 17 is accepted, and
  // the following fall qualifies at edge len+18.
  task automatic test_glitch(input int len);
    logic exp_sign;
    logic exp_chg;
    logic exp_busy;
    int   last;
    last = (len >= 17) ? len + 20 : len + 6;
    for (int e = 0; e <= last; e++) begin
      raw = (e < len);
      step();
      if (len >= 17) begin
        exp_sign = (e >= 18) && (e < len + 18);
        exp_chg  = (e == 18) || (e == len + 18);
        exp_busy = ((e >= 2) && (e <= 17)) || ((e >= 19) && (e < len + 18));
      end else begin
        exp_sign = 1'b0;
        exp_chg  = 1'b0;
        exp_busy = (e >= 2) && (e <= len + 1);
      end
      vectors++;
      if ({sign, chg, busy} !== {exp_sign, exp_chg, exp_busy}) begin
        miscompares++;
        $display("FAIL glitch_len%0d edge %0d: sign/chg/busy got %b expected %b",
                 len, e, {sign, chg, busy}, {exp_sign, exp_chg, exp_busy});
      end
    end
  endtask

  // Toggle every 3 cycles for 40 cycles, then hold 1: sign rises at edge 58.
  task automatic test_bounce();
    logic exp_sign;
    logic exp_chg;
    for (int e = 0; e <= 62; e++) begin
      raw = (e >= 40) ? 1'b1 : (((e / 3) % 2) == 0);
      step();
      exp_sign = (e >= 58);
      exp_chg  = (e == 58);
      vectors++;
      if ({sign, chg} !== {exp_sign, exp_chg}) begin
        miscompares++;
        $display("FAIL bounce edge %0d: sign/chg got %b expected %b",
                 e, {sign, chg}, {exp_sign, exp_chg});
      end
    end
  endtask

  // en high on edges 3,7,11,...; CHECK entered at edge 2, the 16th tick is edge 63.
  task automatic test_gated();
    logic exp_sign;
    logic exp_chg;
    logic exp_busy;
    raw = 1'b0;
    for (int e = 0; e <= 66; e++) begin
      en = ((e % 4) == 3);
      step();
      exp_sign = (e < 63);
      exp_chg  = (e == 63);
      exp_busy = (e >= 2) && (e < 63);
      vectors++;
      if ({sign, chg, busy} !== {exp_sign, exp_chg, exp_busy}) begin
        miscompares++;
        $display("FAIL gated edge %0d: sign/chg/busy got %b expected %b",
                 e, {sign, chg, busy}, {exp_sign, exp_chg, exp_busy});
      end
    end
    en = 1'b1;
  endtask

  // Reset pulled mid-qualification; the full sequence restarts on release.
  task automatic test_reset_mid_check();
    logic exp_sign;
    logic exp_chg;
    logic exp_busy;
    raw = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midchk_busy_before_reset: got %b expected 1", busy);
    end
    rstn = 1'b0;
    #1;
    vectors++;
    if ({sign, chg, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL midchk_reset_entry: got %b expected 000", {sign, chg, busy});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({sign, chg, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL midchk_in_reset cycle %0d: got %b expected 000", i,
                 {sign, chg, busy});
      end
    end
    rstn = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      step();
      exp_sign = (e >= 18);
      exp_chg  = (e == 18);
      exp_busy = (e >= 2) && (e < 18);
      vectors++;
      if ({sign, chg, busy} !== {exp_sign, exp_chg, exp_busy}) begin
        miscompares++;
        $display("FAIL midchk_after_release edge %0d: got %b expected %b",
                 e, {sign, chg, busy}, {exp_sign, exp_chg, exp_busy});
      end
    end
  endtask

  // DEBOUNCE_CYCLES = 1: a 1-clock pulse is rejected; a 2-clock pulse
  // qualifies at edge 3 and the return qualifies at edge 5.
  task automatic test_dc1(input int len);
    logic exp_sign;
    logic exp_chg;
    logic exp_busy;
    for (int e = 0; e <= 7; e++) begin
      raw1 = (e < len);
      step();
      if (len >= 2) begin
        exp_sign = (e == 3) || (e == 4);
        exp_chg  = (e == 3) || (e == 5);
        exp_busy = (e == 2) || (e == 4);
      end else begin
        exp_sign = 1'b0;
        exp_chg  = 1'b0;
        exp_busy = (e == 2);
      end
      vectors++;
      if ({sign1, chg1, busy1} !== {exp_sign, exp_chg, exp_busy}) begin
        miscompares++;
        $display("FAIL dc1_len%0d edge %0d: sign/chg/busy got %b expected %b",
                 len, e, {sign1, chg1, busy1}, {exp_sign, exp_chg, exp_busy});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn = 1'b0;
    raw  = 1'b0;
    raw1 = 1'b0;
    en   = 1'b1;
    test_reset();
    test_step(1'b1);
    idle(4);
    test_step(1'b0);
    idle(4);
    test_glitch(16);
    idle(4);
    test_glitch(17);
    idle(4);
    test_bounce();
    idle(4);
    test_gated();
    idle(4);
    test_reset_mid_check();
    idle(4);
    test_dc1(1);
    idle(4);
    test_dc1(2);
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
Upstream conditioning stage for the falling-edge detector. It takes an asynchronous, possibly bouncing input (button, external line), synchronises it into clk_i, and filters it with a counter-based debouncer. It emits a clean level, sign_o, which drives the edge detector's sign_i, plus a one-cycle change pulse. Debounce counting advances only on en_i ticks, so a shared prescaler can set the time base.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal range ≥2.
DEBOUNCE_CYCLES, 16, enabled cycles the synchronised input must stay at the new level before sign_o follows; legal range ≥1.
RESET_VAL, 1'b0, reset level of the synchroniser chain and sign_o.

Ports:
clk_i  input  1  system clock; all state updates on the rising edge.
rstn_i  input  1  asynchronous active-low reset.
raw_i  input  1  asynchronous raw input; no timing relation to clk_i.
en_i  input  1  debounce tick enable; tie to 1 for per-clock counting.
sign_o  output  1  debounced, synchronous level; registered.
chg_o  output  1  one-cycle pulse when sign_o changes; registered.
busy_o  output  1  high while the FSM is in CHECK; registered or decoded from the state register.

Behaviour:
- Clock and reset: single clock clk_i. Reset rstn_i is asynchronous, active-low.
- Reset values: sync chain = RESET_VAL, sign_o = RESET_VAL, chg_o = 0, busy_o = 0, FSM = STABLE, cnt = 0.
- Synchroniser:
  - raw_i shifts through SYNC_STAGES flops.
  - sync_s is the last stage. Only sync_s is used downstream.
- Counter: cnt width is localparam CNT_W = $clog2(DEBOUNCE_CYCLES+1). cnt never wraps.
- FSM state STABLE:
  - If sync_s == sign_o: hold.
  - If sync_s != sign_o: go to CHECK and set cnt = 0. This edge does not count as a debounce tick, even if en_i = 1.
- FSM state CHECK (busy_o = 1), evaluated every edge in this priority order:
  1. sync_s == sign_o (glitch): go to STABLE, cnt = 0, sign_o unchanged, no chg_o. This takes priority even on the edge that would otherwise complete the count.
  2. en_i = 1 and cnt == DEBOUNCE_CYCLES-1: sign_o <= sync_s, chg_o <= 1 for exactly one cycle, go to STABLE, cnt = 0.
  3. en_i = 1: cnt <= cnt + 1.
  4. en_i = 0: hold cnt and state.
- Latency with en_i = 1: raw_i changes before edge k.
  - sign_o and chg_o update at edge k + SYNC_STAGES + DEBOUNCE_CYCLES.
  - Defaults give 18 cycles.
- Minimum accepted pulse: raw_i must hold the new level for DEBOUNCE_CYCLES+1 consecutive clocks. Shorter pulses are rejected.
- chg_o timing:
  - Asserted in the same cycle sign_o takes its new value; low otherwise.
  - Never asserted two cycles in a row, because a return change needs at least DEBOUNCE_CYCLES+1 further cycles.
- Reset mid-CHECK: all state returns to reset values immediately. No chg_o is produced on reset entry or release.
- After reset release: if raw_i != RESET_VAL, the normal debounce sequence follows, and one chg_o pulse occurs once sign_o settles.
- Boundary DEBOUNCE_CYCLES = 1: the first enabled edge in CHECK completes the update, provided sync_s still differs from sign_o.

Test Plan:
1. Reset check: assert rstn_i with raw_i toggling -> sign_o = 0, chg_o = 0, busy_o = 0 throughout reset. Release reset with raw_i = 0 -> outputs stay 0 and no chg_o.
2. Clean rising step (defaults, en_i = 1): raw_i 0→1 before edge 0 ->
   - busy_o = 1 from edge 2.
   - sign_o = 1 and chg_o = 1 at edge 18; chg_o = 0 at edge 19.
   - Repeat 1→0 -> same 18-cycle latency with one chg_o pulse. The downstream falling-edge detector fires exactly once.
3. Glitch rejection: raw_i high for 16 clocks then low -> sign_o stays 0, no chg_o, busy_o returns to 0. The same stimulus with 17 clocks -> sign_o = 1 with one chg_o.
4. Bounce burst: raw_i toggles 0/1 every 3 cycles for 40 cycles, then holds 1 -> sign_o = 1 exactly 18 cycles after the final transition, with a single chg_o pulse.
5. Gated ticks: en_i high one cycle in four, DEBOUNCE_CYCLES = 16, raw_i steady at its new level -> sign_o updates on the 16th en_i edge after CHECK entry (about 64 cycles). cnt holds during en_i = 0 cycles.
6. Reset mid-CHECK: raw_i 0→1, then pull rstn_i low at cycle 10 for 3 cycles with raw_i held at 1 -> outputs reset, no chg_o during reset. After release, sign_o rises 18 cycles later with one chg_o.
